// File: rtl/word_demux4_reg.sv
// One-deep registered demux: routes each upstream word to one of four channel slots (optional broadcast to all four with WORD_DEMUX_BCAST_EN).
// Latency: 1 cycle from upstream accept to o_valid[ch]; a slot that drains in the same cycle is refilled without a bubble.
// Backpressure: o_ready drops only when the target slot (all slots when broadcasting) is FULL and its consumer is not ready.
module word_demux4_reg (
    input  logic        i_clk,
    input  logic        i_rst_n,
`ifdef WORD_DEMUX_BCAST_EN
    input  logic        i_bcast,
`endif
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [0:1]  i_sel,
    input  logic [0:15] i_val,
    output logic [0:15] o_val0,
    output logic [0:15] o_val1,
    output logic [0:15] o_val2,
    output logic [0:15] o_val3,
    output logic [0:3]  o_valid,
    input  logic [0:3]  i_ready
);

    logic [0:3]  full_q;
    logic [0:3]  full_d;
    logic [0:15] val_q [0:3];
    logic [0:15] val_d [0:3];

    logic [1:0]  ch;
    logic [0:3]  avail;
    logic [0:3]  wr;
    logic        accept;
    logic        bcast;

`ifdef WORD_DEMUX_BCAST_EN
    assign bcast = i_bcast;
`else
    assign bcast = 1'b0;
`endif

    always_comb begin
        ch      = {i_sel[0], i_sel[1]};
        // A slot can take a word if it is empty or is draining this cycle.
        avail   = ~full_q | i_ready;
        o_ready = bcast ? (&avail) : avail[ch];
        accept  = i_valid & o_ready;
        wr      = '0;
        full_d  = full_q;
        for (int n = 0; n < 4; n++) begin
            wr[n]     = accept & (bcast | (ch == 2'(n)));
            full_d[n] = wr[n] | (full_q[n] & ~i_ready[n]);
            val_d[n]  = wr[n] ? i_val : val_q[n];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            full_q <= '0;
            for (int n = 0; n < 4; n++) begin
                val_q[n] <= '0;
            end
        end else begin
            full_q <= full_d;
            for (int n = 0; n < 4; n++) begin
                val_q[n] <= val_d[n];
            end
        end
    end

    assign o_valid = full_q;
    assign o_val0  = val_q[0];
    assign o_val1  = val_q[1];
    assign o_val2  = val_q[2];
    assign o_val3  = val_q[3];

endmodule

// File: tb/tb_word_demux4_reg.sv
// Scoreboard bench for word_demux4_reg: driver predicts readiness and queues accepted words per channel; monitor retires them on downstream transfers.
module tb_word_demux4_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [0:1]  i_sel = '0;
    logic [0:15] i_val = '0;
    logic [0:15] o_val0, o_val1, o_val2, o_val3;
    logic [0:3]  o_valid;
    logic [0:3]  i_ready = '0;
    logic        bcast = 1'b0;

    always #5 clk = ~clk;

    word_demux4_reg dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
`ifdef WORD_DEMUX_BCAST_EN
        .i_bcast (bcast),
`endif
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_sel   (i_sel),
        .i_val   (i_val),
        .o_val0  (o_val0),
        .o_val1  (o_val1),
        .o_val2  (o_val2),
        .o_val3  (o_val3),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    logic [0:15] ov [0:3];
    assign ov[0] = o_val0;
    assign ov[1] = o_val1;
    assign ov[2] = o_val2;
    assign ov[3] = o_val3;

    // Reference model: per channel, the words accepted but not yet delivered (oldest first).
    logic [15:0] qd [0:3][0:1];
    int          qn [0:3];

    int n_cmp  = 0;
    int n_fail = 0;
    bit armed  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [0:1] s,
                        input logic [0:15] d, input logic [0:3] r, input logic b);
        int  c;
        bit  exp_rdy;
        @(negedge clk);
        rst_n = rst; i_valid = v; i_sel = s; i_val = d; i_ready = r; bcast = b;
        #1;
        c = 2 * int'(s[0]) + int'(s[1]);
        if (b) begin
            exp_rdy = 1'b1;
            for (int n = 0; n < 4; n++) if (!(qn[n] == 0 || r[n])) exp_rdy = 1'b0;
        end else begin
            exp_rdy = (qn[c] == 0) || r[c];
        end
        if (armed) begin
            for (int n = 0; n < 4; n++) chk($sformatf("valid%0d", n), 32'(o_valid[n]), 32'(qn[n] != 0));
            chk("ready", 32'(o_ready), 32'(exp_rdy));
        end
        if (!rst) begin
            for (int n = 0; n < 4; n++) qn[n] = 0;
        end else if (v && exp_rdy) begin
            for (int n = 0; n < 4; n++) begin
                if (b || n == c) begin
                    if (qn[n] >= 2) begin
                        n_fail++;
                        $display("FAIL model_overflow ch%0d: depth %0d limit 1", n, qn[n]);
                    end else begin
                        qd[n][qn[n]] = d;
                        qn[n]++;
                    end
                end
            end
        end
    endtask

    // Monitor: just before each edge, check held words and retire those transferring.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (armed && rst_n) begin
                for (int n = 0; n < 4; n++) begin
                    if (o_valid[n]) begin
                        if (qn[n] == 0) begin
                            n_cmp++; n_fail++;
                            $display("FAIL spurious_word ch%0d: got %h expected none", n, ov[n]);
                        end else begin
                            chk($sformatf("data%0d", n), 32'(ov[n]), 32'(qd[n][0]));
                            if (i_ready[n]) begin
                                qd[n][0] = qd[n][1];
                                qn[n]--;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic after_edge;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [0:1]  s;
        logic [0:3]  r;
        logic [0:15] d;
        logic        b;
        for (int n = 0; n < 4; n++) qn[n] = 0;

        // Reset: outputs clear and o_ready high while held.
        step(1'b0, 1'b1, 2'b01, 16'hFFFF, 4'b0000, 1'b0);
        armed = 1'b1;
        step(1'b0, 1'b0, 2'b00, 16'h0000, 4'b0000, 1'b0);
        after_edge();
        chk("rst_val0", 32'(o_val0), 32'h0);
        chk("rst_val3", 32'(o_val3), 32'h0);

        // Single word to channel 2.
        step(1'b1, 1'b1, 2'b10, 16'hA5C3, 4'b0000, 1'b0);
        after_edge();
        chk("c025_valid", 32'(o_valid), 32'b0010);
        chk("c025_val2", 32'(o_val2), 32'hA5C3);

        // Channel 1 blocked: second word refused, held word kept.
        step(1'b1, 1'b1, 2'b01, 16'h1111, 4'b0000, 1'b0);
        step(1'b1, 1'b1, 2'b01, 16'h2222, 4'b0000, 1'b0);
        after_edge();
        chk("c026_val1", 32'(o_val1), 32'h1111);

        // Channel 0 replacement in the same cycle as its transfer.
        step(1'b1, 1'b1, 2'b00, 16'h0001, 4'b0000, 1'b0);
        step(1'b1, 1'b1, 2'b00, 16'h0002, 4'b1000, 1'b0);
        after_edge();
        chk("c027_val0", 32'(o_val0), 32'h0002);
        chk("c027_vld0", 32'(o_valid[0]), 32'h1);

        // Fill channel 3, then drain all four at once.
        step(1'b1, 1'b1, 2'b11, 16'h3333, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 2'b00, 16'h0000, 4'b1111, 1'b0);
        after_edge();
        chk("c028_valid", 32'(o_valid), 32'b0000);

        // Reset with channels 0 and 3 full and an accept pending.
        step(1'b1, 1'b1, 2'b00, 16'h00AA, 4'b0000, 1'b0);
        step(1'b1, 1'b1, 2'b11, 16'h00BB, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 2'b01, 16'h00CC, 4'b1111, 1'b0);
        after_edge();
        chk("c029_valid", 32'(o_valid), 32'b0000);
        chk("c029_val0", 32'(o_val0), 32'h0);
        chk("c029_val1", 32'(o_val1), 32'h0);
        chk("c029_val3", 32'(o_val3), 32'h0);

`ifdef WORD_DEMUX_BCAST_EN
        step(1'b1, 1'b1, 2'b01, 16'hBEEF, 4'b0000, 1'b1);
        after_edge();
        chk("c030_valid", 32'(o_valid), 32'b1111);
        chk("c030_val2", 32'(o_val2), 32'hBEEF);
        step(1'b1, 1'b0, 2'b00, 16'h0000, 4'b1110, 1'b0);
        step(1'b1, 1'b1, 2'b00, 16'hBEEF, 4'b1110, 1'b1);
`endif

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 600; i++) begin
            s = 2'($urandom_range(0, 3));
            r = 4'($urandom);
            d = 16'($urandom);
`ifdef WORD_DEMUX_BCAST_EN
            b = ($urandom_range(0, 7) == 0);
`else
            b = 1'b0;
`endif
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), s, d, r, b);
        end
        step(1'b1, 1'b0, 2'b00, 16'h0000, 4'b1111, 1'b0);
        step(1'b1, 1'b0, 2'b00, 16'h0000, 4'b1111, 1'b0);
        after_edge();
        chk("drained", 32'(o_valid), 32'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
